// File: rtl/usb_pkg.sv
// Shared types and line-code constants for the USB transmit line encoder.
// Consumers: usb_tx_line_encoder, nrzi_encoder.
package usb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_STUFF,
    S_SE0_A,
    S_SE0_B,
    S_EOP_J
  } state_t;

  localparam int STUFF_LEN_DEF = 6;

  // {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [1:0] line_of(input logic dp);
    return dp ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/nrzi_encoder.sv
// Line driver: NRZI level register and registered dp/dm outputs.
// NRZI coding is compiled in only when USB_TX_NRZI_EN is defined.
module nrzi_encoder
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_bit,
  input  logic i_se0,
  input  logic i_idle,
  output logic o_dp,
  output logic o_dm
);

  logic       r_level;
  logic [1:0] r_line;
  logic       w_level_nx;
  logic       w_dbit;

`ifdef USB_TX_NRZI_EN
  assign w_level_nx = i_bit ? r_level : ~r_level;
  assign w_dbit     = w_level_nx;
`else
  assign w_level_nx = r_level;
  assign w_dbit     = i_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b1;
      r_line  <= LINE_J;
    end else if (i_idle) begin
      r_level <= 1'b1;
      r_line  <= LINE_J;
    end else if (i_se0) begin
      r_line  <= LINE_SE0;
    end else if (i_load) begin
      r_level <= w_level_nx;
      r_line  <= line_of(w_dbit);
    end
  end

  assign o_dp = r_line[1];
  assign o_dm = r_line[0];

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit stuffing, EOP generation, line drive.
// Define USB_TX_NRZI_EN to compile in NRZI coding of the line.
module usb_tx_line_encoder
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_in,
  input  logic bit_last,
  output logic bit_req,
  output logic dp,
  output logic dm,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(STUFF_LEN + 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_ones;
  logic [CW-1:0] w_ones_nx;
  logic [CW-1:0] w_ones_inc;
  logic          r_last;
  logic          w_last_nx;
  logic          r_done;
  logic          w_hit;
  logic          w_load;
  logic          w_bit;
  logic          w_se0;
  logic          w_idle;

  assign w_ones_inc = r_ones + CW'(1);
  assign w_hit      = bit_in && (w_ones_inc == CW'(STUFF_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ones  <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ones  <= w_ones_nx;
      r_last  <= w_last_nx;
      r_done  <= (r_state == S_EOP_J);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ones_nx = r_ones;
    w_last_nx = r_last;
    w_load    = 1'b0;
    w_bit     = 1'b0;
    w_se0     = 1'b0;
    w_idle    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_idle    = 1'b1;
        w_ones_nx = '0;
        w_last_nx = 1'b0;
        if (start) w_next = S_DATA;
      end
      S_DATA: begin
        w_load    = 1'b1;
        w_bit     = bit_in;
        w_last_nx = bit_last;
        w_ones_nx = bit_in ? w_ones_inc : '0;
        if (w_hit)         w_next = S_STUFF;
        else if (bit_last) w_next = S_SE0_A;
      end
      // stuffed 0 consumes nothing; r_last says where to resume
      S_STUFF: begin
        w_load    = 1'b1;
        w_bit     = 1'b0;
        w_ones_nx = '0;
        w_next    = r_last ? S_SE0_A : S_DATA;
      end
      S_SE0_A: begin
        w_se0  = 1'b1;
        w_next = S_SE0_B;
      end
      S_SE0_B: begin
        w_se0  = 1'b1;
        w_next = S_EOP_J;
      end
      S_EOP_J: begin
        w_idle = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  nrzi_encoder u_nrzi (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_bit  (w_bit),
    .i_se0  (w_se0),
    .i_idle (w_idle),
    .o_dp   (dp),
    .o_dm   (dm)
  );

  assign bit_req = (r_state == S_DATA);
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed + randomized bench for usb_tx_line_encoder against a
// packet-level model of stuffing, optional NRZI and EOP.
module tb_usb_tx_line_encoder;

  localparam int SL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_last = 1'b0;
  logic bit_req;
  logic dp;
  logic dm;
  logic busy;
  logic done;

  usb_tx_line_encoder #(.STUFF_LEN(SL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bit_in   (bit_in),
    .bit_last (bit_last),
    .bit_req  (bit_req),
    .dp       (dp),
    .dm       (dm),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic       pkt[$];
  logic [1:0] exp_line[$];
  logic       exp_req[$];
  logic [1:0] obs_line[$];
  logic       obs_req[$];
  logic       obs_done[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Stuff the packet, line-code it, then append SE0, SE0, J.
  task automatic build_exp();
    logic raw[$];
    logic rq[$];
    int   cnt;
`ifdef USB_TX_NRZI_EN
    logic lvl;
    lvl = 1'b1;
`endif
    cnt = 0;
    exp_line.delete();
    exp_req.delete();
    foreach (pkt[i]) begin
      raw.push_back(pkt[i]);
      rq.push_back(1'b1);
      if (pkt[i]) begin
        cnt++;
        if (cnt == SL) begin
          raw.push_back(1'b0);
          rq.push_back(1'b0);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
    foreach (raw[i]) begin
      logic d;
`ifdef USB_TX_NRZI_EN
      if (!raw[i]) lvl = ~lvl;
      d = lvl;
`else
      d = raw[i];
`endif
      exp_line.push_back({d, ~d});
      exp_req.push_back(rq[i]);
    end
    exp_line.push_back(2'b00); exp_req.push_back(1'b0);
    exp_line.push_back(2'b00); exp_req.push_back(1'b0);
    exp_line.push_back(2'b10); exp_req.push_back(1'b0);
  endtask

  // Send pkt; s1/s2 are loop cycles on which start is pulsed again.
  task automatic run_pkt(input int s1, input int s2);
    int   idx;
    logic fin;
    logic r;
    idx = 0;
    fin = 1'b0;
    build_exp();
    obs_line.delete();
    obs_req.delete();
    obs_done.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      bit_in   = (idx < pkt.size()) ? pkt[idx] : 1'b0;
      bit_last = (idx == pkt.size() - 1);
      start    = (i == s1) || (i == s2);
      r = bit_req;
      obs_req.push_back(r);
      @(posedge clk);
      if (r) idx++;
      #1;
      obs_line.push_back({dp, dm});
      obs_done.push_back(done);
      fin = done;
    end
    start    = 1'b0;
    bit_in   = 1'b0;
    bit_last = 1'b0;
    chk("finish", fin, 1);
    chk("n_line", obs_line.size(), exp_line.size());
    for (int i = 0; i < obs_line.size() && i < exp_line.size(); i++) begin
      chk($sformatf("line[%0d]", i), obs_line[i], exp_line[i]);
      chk($sformatf("req[%0d]", i), obs_req[i], exp_req[i]);
      chk($sformatf("done[%0d]", i), obs_done[i],
          (i == exp_line.size() - 1) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  function automatic int first_se0();
    foreach (obs_line[i]) if (obs_line[i] == 2'b00) return i;
    return -1;
  endfunction

  initial begin
    logic [7:0] v;
    logic [7:0] w;
    logic       acc;
    logic       acc2;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dp", dp, 1);
    chk("rst_dm", dm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", bit_req, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_no_start", busy, 0);

    // eight zeros
    pkt.delete();
    repeat (8) pkt.push_back(1'b0);
    run_pkt(-1, -1);
`ifdef USB_TX_NRZI_EN
    v = '0;
    for (int i = 0; i < 8 && i < obs_line.size(); i++)
      v = {v[6:0], obs_line[i][1]};
    chk("nrzi8_dp", v, 8'b01010101);
    if (obs_line.size() >= 11) begin
      chk("nrzi8_se0a", obs_line[8], 2'b00);
      chk("nrzi8_se0b", obs_line[9], 2'b00);
      chk("nrzi8_j", obs_line[10], 2'b10);
    end
`endif

    // 1,0,1,1
    pkt.delete();
    pkt.push_back(1'b1);
    pkt.push_back(1'b0);
    pkt.push_back(1'b1);
    pkt.push_back(1'b1);
    run_pkt(-1, -1);
`ifndef USB_TX_NRZI_EN
    v = '0;
    w = '0;
    for (int i = 0; i < 4 && i < obs_line.size(); i++) begin
      v = {v[6:0], obs_line[i][1]};
      w = {w[6:0], obs_line[i][0]};
    end
    chk("raw_dp", v, 8'b00001011);
    chk("raw_dm", w, 8'b00000100);
`endif

    // seven ones: one stuffed 0 after the sixth
    pkt.delete();
    repeat (7) pkt.push_back(1'b1);
    run_pkt(-1, -1);
    chk("seven_bits", first_se0(), 8);
    v = '0;
    for (int i = 0; i < 8 && i < obs_req.size(); i++)
      v = {v[6:0], obs_req[i]};
    chk("seven_req", v, 8'b11111101);

    // six ones ending the packet: stuff precedes EOP
    pkt.delete();
    repeat (6) pkt.push_back(1'b1);
    run_pkt(-1, -1);
    chk("six_bits", first_se0(), 7);

    // start in DATA and in EOP_J is ignored
    pkt.delete();
    pkt.push_back(1'b1);
    pkt.push_back(1'b0);
    pkt.push_back(1'b1);
    run_pkt(1, 5);
    acc = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 acc = acc | busy | done;
    end
    chk("no_second_pkt", acc, 0);

    // random packets biased towards 1s
    for (int k = 0; k < 6; k++) begin
      pkt.delete();
      repeat ($urandom_range(1, 20))
        pkt.push_back($urandom_range(0, 3) != 0);
      run_pkt(-1, -1);
    end

    // reset mid-DATA abandons the packet
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bit_in   = 1'($urandom_range(0, 1));
      bit_last = 1'b0;
    end
    chk("mid_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_dp", dp, 1);
    chk("arst_dm", dm, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("mrst_dp", dp, 1);
    chk("mrst_dm", dm, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_req", bit_req, 0);
    chk("mrst_done", done, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    bit_in = 1'b0;
    acc  = 1'b0;
    acc2 = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      acc  = acc | done;
      acc2 = acc2 | busy | ~dp | dm;
    end
    chk("mrst_no_done", acc, 0);
    chk("mrst_idle_j", acc2, 0);

    // recovery after reset
    pkt.delete();
    repeat ($urandom_range(5, 15))
      pkt.push_back($urandom_range(0, 1) != 0);
    run_pkt(-1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
